// File: rtl/multi_cycle_core_if.sv
// Memory-side bus of the multi-cycle core: an instruction fetch port and a
// data load/store port, each a request/ready handshake.
interface multi_cycle_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 4
);
  localparam int RSEL_W  = $clog2(NUM_REGS);
  localparam int INSTR_W = 4 + 2 * RSEL_W + ADDR_WIDTH;

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic [INSTR_W-1:0]    imem_rdata;

  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ready;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  // Core side: drives requests, receives ready/data.
  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  // Memory side: answers requests.
  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/multi_cycle_core.sv
// Multi-cycle accumulator-style core: FETCH -> DECODE -> EXECUTE -> (MEM) ->
// (WB), with variable-latency instruction and data memories.
module multi_cycle_core #(
  parameter  int DATA_WIDTH = 8,
  parameter  int ADDR_WIDTH = 8,
  parameter  int NUM_REGS   = 4,
  localparam int RSEL_W     = $clog2(NUM_REGS),
  localparam int INSTR_W    = 4 + 2 * RSEL_W + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  clear,
  multi_cycle_core_if.master    bus,
  output logic [INSTR_W-1:0]    programOut,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  illegal,
  output logic [15:0]           retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDI  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_LD   = 4'd6,
    OP_ST   = 4'd7,
    OP_JMP  = 4'd8,
    OP_JZ   = 4'd9,
    OP_HALT = 4'd15
  } opcode_t;

  state_t                state;
  logic [INSTR_W-1:0]    ir;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] a_op;
  logic [DATA_WIDTH-1:0] b_op;
  logic [DATA_WIDTH-1:0] result;

  // Instruction fields, taken from the latched IR.
  opcode_t               op;
  logic [RSEL_W-1:0]     rd;
  logic [RSEL_W-1:0]     rs;
  logic [ADDR_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] imm_ext;

  assign op      = opcode_t'(ir[INSTR_W-1 -: 4]);
  assign rd      = ir[INSTR_W-5 -: RSEL_W];
  assign rs      = ir[INSTR_W-5-RSEL_W -: RSEL_W];
  assign imm     = ir[ADDR_WIDTH-1:0];
  assign imm_ext = DATA_WIDTH'(imm);

  // Requests follow the state but drop immediately while clear is held, so an
  // abandoned access is never presented during reset.
  logic fetch_active;
  logic mem_active;

  assign fetch_active   = (state == S_FETCH) && !clear;
  assign mem_active     = (state == S_MEM) && !clear;
  assign bus.imem_req   = fetch_active;
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = mem_active;
  assign bus.dmem_we    = mem_active && (op == OP_ST);
  assign bus.dmem_addr  = imm;
  assign bus.dmem_wdata = a_op;
  assign programOut     = ir;

  // Sequencer, datapath registers and register file, all advanced in one FSM.
  // NOTE: every state element here uses <= so all updates see the values from
  // before the edge; mixing in = would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= S_FETCH;
      pc      <= '0;
      ir      <= '0;
      a_op    <= '0;
      b_op    <= '0;
      result  <= '0;
      retired <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      // NOTE: the register file is built from flops, so it is cleared with the
      // rest of the state; a RAM-based file could not be reset this way.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.imem_ready) begin
            ir    <= bus.imem_rdata;
            pc    <= pc + ADDR_WIDTH'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_op  <= regs[rd];
          b_op  <= regs[rs];
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          case (op)
            OP_LDI: begin result <= imm_ext;     state <= S_WB; end
            OP_ADD: begin result <= a_op + b_op; state <= S_WB; end
            OP_SUB: begin result <= a_op - b_op; state <= S_WB; end
            OP_AND: begin result <= a_op & b_op; state <= S_WB; end
            OP_OR:  begin result <= a_op | b_op; state <= S_WB; end
            OP_LD, OP_ST: state <= S_MEM;
            OP_JMP: begin
              pc      <= imm;
              retired <= retired + 16'd1;
              state   <= S_FETCH;
            end
            OP_JZ: begin
              if (a_op == '0) pc <= imm;
              retired <= retired + 16'd1;
              state   <= S_FETCH;
            end
            OP_HALT: begin
              halted  <= 1'b1;
              retired <= retired + 16'd1;
              state   <= S_HALT;
            end
            OP_NOP: begin
              retired <= retired + 16'd1;
              state   <= S_FETCH;
            end
            default: begin
              // Undefined opcodes retire as NOP and leave a sticky flag.
              illegal <= 1'b1;
              retired <= retired + 16'd1;
              state   <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            if (op == OP_ST) begin
              retired <= retired + 16'd1;
              state   <= S_FETCH;
            end else begin
              result <= bus.dmem_rdata;
              state  <= S_WB;
            end
          end
        end
        S_WB: begin
          regs[rd] <= result;
          retired  <= retired + 16'd1;
          state    <= S_FETCH;
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_core.sv
// Directed bench for multi_cycle_core: a default 8-bit/4-register instance
// with stallable memories, and a 16-bit/8-register instance with zero-wait
// memories.
module tb_multi_cycle_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- instance 1: DATA_WIDTH=8, NUM_REGS=4, INSTR_W=16 -------
  logic        clear     = 1'b1;
  logic        imem_hold = 1'b0;
  logic        dmem_hold = 1'b0;
  logic [15:0] prog1;
  logic [7:0]  pc1;
  logic        halted1;
  logic        illegal1;
  logic [15:0] retired1;
  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  int          cyc;

  multi_cycle_core_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(4)) bus1 ();

  assign bus1.imem_ready = !imem_hold;
  assign bus1.imem_rdata = imem[bus1.imem_addr];
  assign bus1.dmem_ready = !dmem_hold;
  assign bus1.dmem_rdata = dmem[bus1.dmem_addr];

  // Store completes at the coming edge; the model records it half a cycle early.
  always @(negedge clk)
    if (bus1.dmem_req && bus1.dmem_we && bus1.dmem_ready) dmem[bus1.dmem_addr] = bus1.dmem_wdata;

  // Cycles since the last clear edge.
  always @(posedge clk)
    if (clear) cyc <= 0;
    else       cyc <= cyc + 1;

  multi_cycle_core #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(4)) dut1 (
    .clk        (clk),
    .clear      (clear),
    .bus        (bus1),
    .programOut (prog1),
    .pc         (pc1),
    .halted     (halted1),
    .illegal    (illegal1),
    .retired    (retired1)
  );

  // ---------------- instance 2: DATA_WIDTH=16, NUM_REGS=8, INSTR_W=18 ------
  logic        clear2 = 1'b1;
  logic [17:0] prog2;
  logic [7:0]  pc2;
  logic        halted2;
  logic        illegal2;
  logic [15:0] retired2;
  logic [17:0] imem2 [256];
  logic [15:0] dmem2 [256];

  multi_cycle_core_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_REGS(8)) bus2 ();

  assign bus2.imem_ready = 1'b1;
  assign bus2.imem_rdata = imem2[bus2.imem_addr];
  assign bus2.dmem_ready = 1'b1;
  assign bus2.dmem_rdata = dmem2[bus2.dmem_addr];

  always @(negedge clk)
    if (bus2.dmem_req && bus2.dmem_we) dmem2[bus2.dmem_addr] = bus2.dmem_wdata;

  multi_cycle_core #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_REGS(8)) dut2 (
    .clk        (clk),
    .clear      (clear2),
    .bus        (bus2),
    .programOut (prog2),
    .pc         (pc2),
    .halted     (halted2),
    .illegal    (illegal2),
    .retired    (retired2)
  );

  // ---------------- helpers ----------------
  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [17:0] enc2(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 256; i++) begin
      imem[i] = '0;
      dmem[i] = '0;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    repeat (2) step();
    clear = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted1 && n < budget) begin step(); n++; end
  endtask

  task automatic wait_fetch(input logic [7:0] addr, input int budget);
    int n = 0;
    while (!(bus1.imem_req && bus1.imem_addr == addr) && n < budget) begin step(); n++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_mems();
    clear = 1'b1;
    repeat (3) step();
    tests++; if (bus1.imem_req !== 1'b0) begin fails++; $display("FAIL reset_imem_req: got %0h expected 0", bus1.imem_req); end
    tests++; if (bus1.dmem_req !== 1'b0) begin fails++; $display("FAIL reset_dmem_req: got %0h expected 0", bus1.dmem_req); end
    tests++; if (pc1 !== 8'h00) begin fails++; $display("FAIL reset_pc: got %0h expected 0", pc1); end
    tests++; if (prog1 !== 16'h0000) begin fails++; $display("FAIL reset_ir: got %0h expected 0", prog1); end
    tests++; if (halted1 !== 1'b0 || illegal1 !== 1'b0) begin fails++; $display("FAIL reset_flags: got halted=%0h illegal=%0h expected 0/0", halted1, illegal1); end
    tests++; if (retired1 !== 16'd0) begin fails++; $display("FAIL reset_retired: got %0d expected 0", retired1); end
    clear = 1'b0;
    #1;
    tests++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 8'h00) begin fails++; $display("FAIL reset_first_fetch: got req=%0h addr=%0h expected 1/00", bus1.imem_req, bus1.imem_addr); end
  endtask

  task automatic test_program();
    clear_mems();
    imem[0] = enc(4'd1, 2'd1, 2'd0, 8'd5);     // LDI r1,5
    imem[1] = enc(4'd1, 2'd2, 2'd0, 8'd3);     // LDI r2,3
    imem[2] = enc(4'd2, 2'd1, 2'd2, 8'd0);     // ADD r1,r2
    imem[3] = enc(4'd7, 2'd1, 2'd0, 8'h10);    // ST r1,@0x10
    imem[4] = enc(4'd15, 2'd0, 2'd0, 8'd0);    // HALT
    do_clear();
    wait_halt(100);
    tests++; if (halted1 !== 1'b1) begin fails++; $display("FAIL prog_halted: got %0h expected 1", halted1); end
    tests++; if (cyc !== 19) begin fails++; $display("FAIL prog_cycles: got %0d expected 19", cyc); end
    tests++; if (dmem[8'h10] !== 8'd8) begin fails++; $display("FAIL prog_store: got %0h expected 8", dmem[8'h10]); end
    tests++; if (retired1 !== 16'd5) begin fails++; $display("FAIL prog_retired: got %0d expected 5", retired1); end
    repeat (3) step();
    tests++; if (bus1.imem_req !== 1'b0 || bus1.dmem_req !== 1'b0) begin fails++; $display("FAIL halt_reqs: got imem=%0h dmem=%0h expected 0/0", bus1.imem_req, bus1.dmem_req); end
    tests++; if (pc1 !== 8'd5 || retired1 !== 16'd5) begin fails++; $display("FAIL halt_frozen: got pc=%0h retired=%0d expected 5/5", pc1, retired1); end
  endtask

  task automatic test_wrap_jz();
    int n = 0;
    clear_mems();
    dmem[8'h11] = 8'h77;
    imem[0]     = enc(4'd1, 2'd0, 2'd0, 8'hFF);   // LDI r0,0xFF
    imem[1]     = enc(4'd1, 2'd1, 2'd0, 8'h01);   // LDI r1,1
    imem[2]     = enc(4'd2, 2'd0, 2'd1, 8'h00);   // ADD r0,r1 -> 0
    imem[3]     = enc(4'd7, 2'd0, 2'd0, 8'h11);   // ST r0,@0x11
    imem[4]     = enc(4'd9, 2'd0, 2'd0, 8'h20);   // JZ r0,0x20 (taken)
    imem[8'h20] = enc(4'd9, 2'd1, 2'd0, 8'h40);   // JZ r1,0x40 (not taken)
    imem[8'h21] = enc(4'd15, 2'd0, 2'd0, 8'h00);  // HALT
    do_clear();
    while (pc1 !== 8'h20 && n < 100) begin step(); n++; end
    tests++; if (pc1 !== 8'h20 || bus1.imem_req !== 1'b1 || bus1.imem_addr !== 8'h20) begin fails++; $display("FAIL jz_taken: got pc=%0h req=%0h addr=%0h expected 20/1/20", pc1, bus1.imem_req, bus1.imem_addr); end
    tests++; if (cyc !== 19) begin fails++; $display("FAIL jz_cycles: got %0d expected 19", cyc); end
    wait_halt(100);
    tests++; if (dmem[8'h11] !== 8'h00) begin fails++; $display("FAIL add_wrap: got %0h expected 0", dmem[8'h11]); end
    tests++; if (pc1 !== 8'h22 || halted1 !== 1'b1) begin fails++; $display("FAIL jz_not_taken: got pc=%0h halted=%0h expected 22/1", pc1, halted1); end
    tests++; if (retired1 !== 16'd7) begin fails++; $display("FAIL jz_retired: got %0d expected 7", retired1); end
  endtask

  task automatic test_stall();
    int ld_start;
    int n = 0;
    clear_mems();
    imem[0] = enc(4'd1, 2'd2, 2'd0, 8'h5A);    // LDI r2,0x5A
    imem[1] = enc(4'd7, 2'd2, 2'd0, 8'h40);    // ST r2,@0x40
    imem[2] = enc(4'd6, 2'd3, 2'd0, 8'h40);    // LD r3,@0x40
    imem[3] = enc(4'd7, 2'd3, 2'd0, 8'h41);    // ST r3,@0x41
    imem[4] = enc(4'd15, 2'd0, 2'd0, 8'h00);   // HALT
    do_clear();
    wait_fetch(8'd2, 50);
    ld_start = cyc;
    tests++; if (ld_start !== 8) begin fails++; $display("FAIL ld_start: got %0d expected 8", ld_start); end
    imem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 8'd2 || pc1 !== 8'd2 || prog1 !== enc(4'd7, 2'd2, 2'd0, 8'h40)) begin
        fails++; $display("FAIL fetch_stall_%0d: got req=%0h addr=%0h pc=%0h ir=%0h expected 1/2/2/%0h", i, bus1.imem_req, bus1.imem_addr, pc1, prog1, enc(4'd7, 2'd2, 2'd0, 8'h40));
      end
    end
    imem_hold = 1'b0;
    while (!(bus1.dmem_req && !bus1.dmem_we) && n < 20) begin step(); n++; end
    dmem_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (bus1.dmem_req !== 1'b1 || bus1.dmem_we !== 1'b0 || bus1.dmem_addr !== 8'h40 || bus1.imem_req !== 1'b0) begin
        fails++; $display("FAIL mem_stall_%0d: got req=%0h we=%0h addr=%0h imem_req=%0h expected 1/0/40/0", i, bus1.dmem_req, bus1.dmem_we, bus1.dmem_addr, bus1.imem_req);
      end
    end
    dmem_hold = 1'b0;
    wait_fetch(8'd3, 20);
    tests++; if (cyc - ld_start !== 10) begin fails++; $display("FAIL ld_cycles: got %0d expected 10", cyc - ld_start); end
    wait_halt(50);
    tests++; if (cyc !== 25 || halted1 !== 1'b1) begin fails++; $display("FAIL stall_total: got cyc=%0d halted=%0h expected 25/1", cyc, halted1); end
    tests++; if (dmem[8'h41] !== 8'h5A) begin fails++; $display("FAIL ld_data: got %0h expected 5a", dmem[8'h41]); end
  endtask

  task automatic test_illegal();
    clear_mems();
    dmem[8'h10] = 8'hEE;
    imem[0] = enc(4'd1, 2'd1, 2'd0, 8'd7);     // LDI r1,7
    imem[1] = enc(4'd12, 2'd1, 2'd1, 8'h10);   // undefined opcode 12
    imem[2] = enc(4'd7, 2'd1, 2'd0, 8'h50);    // ST r1,@0x50
    imem[3] = enc(4'd15, 2'd0, 2'd0, 8'h00);   // HALT
    do_clear();
    wait_halt(100);
    tests++; if (illegal1 !== 1'b1) begin fails++; $display("FAIL illegal_flag: got %0h expected 1", illegal1); end
    tests++; if (dmem[8'h50] !== 8'd7 || dmem[8'h10] !== 8'hEE) begin fails++; $display("FAIL illegal_no_effect: got m50=%0h m10=%0h expected 7/ee", dmem[8'h50], dmem[8'h10]); end
    tests++; if (retired1 !== 16'd4 || cyc !== 14 || pc1 !== 8'd4) begin fails++; $display("FAIL illegal_flow: got retired=%0d cyc=%0d pc=%0h expected 4/14/4", retired1, cyc, pc1); end
  endtask

  task automatic test_clear_in_mem();
    int n = 0;
    clear_mems();
    dmem[8'h61] = 8'hAA;
    dmem[8'h62] = 8'hAA;
    imem[0] = enc(4'd1, 2'd1, 2'd0, 8'd9);     // LDI r1,9
    imem[1] = enc(4'd1, 2'd2, 2'd0, 8'd4);     // LDI r2,4
    imem[2] = enc(4'd6, 2'd3, 2'd0, 8'h60);    // LD r3,@0x60 (held waiting)
    dmem_hold = 1'b1;
    do_clear();
    while (!bus1.dmem_req && n < 50) begin step(); n++; end
    tests++; if (bus1.dmem_req !== 1'b1 || bus1.dmem_addr !== 8'h60) begin fails++; $display("FAIL mem_wait: got req=%0h addr=%0h expected 1/60", bus1.dmem_req, bus1.dmem_addr); end
    clear = 1'b1;
    step();
    tests++; if (bus1.dmem_req !== 1'b0 || bus1.imem_req !== 1'b0) begin fails++; $display("FAIL clear_drop: got dmem=%0h imem=%0h expected 0/0", bus1.dmem_req, bus1.imem_req); end
    tests++; if (pc1 !== 8'd0 || prog1 !== 16'd0 || retired1 !== 16'd0 || illegal1 !== 1'b0) begin fails++; $display("FAIL clear_state: got pc=%0h ir=%0h retired=%0d illegal=%0h expected 0/0/0/0", pc1, prog1, retired1, illegal1); end
    clear_mems();
    dmem[8'h61] = 8'hAA;
    dmem[8'h62] = 8'hAA;
    imem[0] = enc(4'd7, 2'd1, 2'd0, 8'h61);    // ST r1,@0x61
    imem[1] = enc(4'd7, 2'd2, 2'd0, 8'h62);    // ST r2,@0x62
    imem[2] = enc(4'd15, 2'd0, 2'd0, 8'h00);   // HALT
    clear = 1'b0;
    dmem_hold = 1'b0;
    #1;
    tests++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 8'd0 || bus1.dmem_req !== 1'b0) begin fails++; $display("FAIL restart: got imem=%0h addr=%0h dmem=%0h expected 1/0/0", bus1.imem_req, bus1.imem_addr, bus1.dmem_req); end
    wait_halt(50);
    tests++; if (dmem[8'h61] !== 8'h00 || dmem[8'h62] !== 8'h00) begin fails++; $display("FAIL regs_cleared: got r1=%0h r2=%0h expected 0/0", dmem[8'h61], dmem[8'h62]); end
    tests++; if (retired1 !== 16'd3 || cyc !== 11) begin fails++; $display("FAIL restart_flow: got retired=%0d cyc=%0d expected 3/11", retired1, cyc); end
  endtask

  task automatic test_jmp_wrap();
    int n = 0;
    clear_mems();
    imem[0]     = enc(4'd8, 2'd0, 2'd0, 8'hFF);  // JMP 0xFF
    imem[8'hFF] = enc(4'd0, 2'd0, 2'd0, 8'h00);  // NOP
    do_clear();
    while (pc1 !== 8'hFF && n < 20) begin step(); n++; end
    tests++; if (pc1 !== 8'hFF || bus1.imem_addr !== 8'hFF || cyc !== 3) begin fails++; $display("FAIL jmp_target: got pc=%0h addr=%0h cyc=%0d expected ff/ff/3", pc1, bus1.imem_addr, cyc); end
    step();
    tests++; if (pc1 !== 8'h00) begin fails++; $display("FAIL pc_wrap: got %0h expected 0", pc1); end
    repeat (2) step();
    tests++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 8'h00 || retired1 !== 16'd2) begin fails++; $display("FAIL wrap_fetch: got req=%0h addr=%0h retired=%0d expected 1/0/2", bus1.imem_req, bus1.imem_addr, retired1); end
  endtask

  task automatic test_param();
    int n = 0;
    for (int i = 0; i < 256; i++) begin
      imem2[i] = '0;
      dmem2[i] = '0;
    end
    imem2[0]     = enc2(4'd9, 3'd5, 3'd0, 8'h10);  // JZ r5,0x10
    imem2[1]     = enc2(4'd15, 3'd0, 3'd0, 8'h00); // HALT
    imem2[8'h10] = enc2(4'd1, 3'd5, 3'd0, 8'h01);  // LDI r5,1
    imem2[8'h11] = enc2(4'd1, 3'd7, 3'd0, 8'hFF);  // LDI r7,0xFF
    imem2[8'h12] = enc2(4'd1, 3'd6, 3'd0, 8'h01);  // LDI r6,1
    imem2[8'h13] = enc2(4'd2, 3'd7, 3'd6, 8'h00);  // ADD r7,r6 -> 0x0100
    imem2[8'h14] = enc2(4'd7, 3'd7, 3'd0, 8'h20);  // ST r7,@0x20
    imem2[8'h15] = enc2(4'd8, 3'd0, 3'd0, 8'hFF);  // JMP 0xFF
    imem2[8'hFF] = enc2(4'd0, 3'd0, 3'd0, 8'h00);  // NOP, pc wraps to 0
    clear2 = 1'b1;
    repeat (2) step();
    clear2 = 1'b0;
    while (!halted2 && n < 200) begin step(); n++; end
    tests++; if (halted2 !== 1'b1 || n !== 35) begin fails++; $display("FAIL p16_halt: got halted=%0h cycles=%0d expected 1/35", halted2, n); end
    tests++; if (dmem2[8'h20] !== 16'h0100) begin fails++; $display("FAIL p16_add: got %0h expected 100", dmem2[8'h20]); end
    tests++; if (pc2 !== 8'd2 || retired2 !== 16'd10 || illegal2 !== 1'b0) begin fails++; $display("FAIL p16_flow: got pc=%0h retired=%0d illegal=%0h expected 2/10/0", pc2, retired2, illegal2); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_wrap_jz();
    test_stall();
    test_illegal();
    test_clear_in_mem();
    test_jmp_wrap();
    test_param();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_cycle_core.md
MULTI_CYCLE_CORE -- requirements
Module: multi_cycle_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8: register/ALU/data-memory word width.
REQ-002 Parameter ADDR_WIDTH, default 8: PC, instruction-address and data-address width, and immediate field width.
REQ-003 Parameter NUM_REGS, default 4: register-file depth, power of two ≥2; RSEL_W = log2(NUM_REGS); INSTR_W = 4 + 2*RSEL_W + ADDR_WIDTH (derived).
REQ-004 Single clock and a synchronous, active-high reset: `clk` rising-edge only; `clear` sampled on `clk`.
REQ-005 clk  input  1  system clock.
REQ-006 clear  input  1  synchronous active-high reset.
REQ-007 imem_req / imem_addr  output  1 / ADDR_WIDTH  instruction fetch request and address.
REQ-008 imem_ready / imem_rdata  input  1 / INSTR_W  fetch complete; instruction valid when imem_ready=1.
REQ-009 dmem_req / dmem_we / dmem_addr / dmem_wdata  output  1 / 1 / ADDR_WIDTH / DATA_WIDTH  data access request, write enable, address, store data.
REQ-010 dmem_ready / dmem_rdata  input  1 / DATA_WIDTH  data access complete; load data valid when dmem_ready=1.
REQ-011 programOut  output  INSTR_W  currently latched instruction register (IR).
REQ-012 pc  output  ADDR_WIDTH  program counter.
REQ-013 halted / illegal  output  1 / 1  HALT executed; sticky flag set by an undefined opcode.
REQ-014 retired  output  16  retired-instruction counter.

Function
REQ-015 IR fields: [INSTR_W-1 -: 4] opcode, then rd (RSEL_W), then rs (RSEL_W), then imm (ADDR_WIDTH) at the LSBs.
REQ-016 Opcodes: 0 NOP; 1 LDI rd=imm (zero-extend or truncate to DATA_WIDTH); 2 ADD rd=rd+rs; 3 SUB rd=rd-rs; 4 AND; 5 OR; 6 LD rd=mem[imm]; 7 ST mem[imm]=rd; 8 JMP pc=imm; 9 JZ if rd==0 then pc=imm; 15 HALT; 10-14 undefined.
REQ-017 FSM states: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
REQ-018 FETCH: imem_req=1 and imem_addr=pc. On an imem_ready cycle: IR<=imem_rdata, pc<=pc+1, go to DECODE. Otherwise stay in FETCH with req held.
REQ-019 DECODE lasts one cycle: latch operands A=reg[rd], B=reg[rs]; go to EXECUTE.
REQ-020 EXECUTE lasts one cycle. ALU/LDI -> WB. LD/ST -> MEM. JMP/JZ(taken) load pc; JMP/JZ/NOP/undefined -> FETCH. HALT -> HALT.
REQ-021 MEM: dmem_req=1, dmem_addr=imm, dmem_we=1 for ST with dmem_wdata=A. Stay in MEM until dmem_ready; then ST -> FETCH, LD -> WB with load data captured.
REQ-022 WB lasts one cycle: write the result to reg[rd]; go to FETCH.
REQ-023 Minimum cycles per instruction with zero-wait memories: NOP/JMP/JZ = 3, ALU/LDI = 4, ST = 4, LD = 5; each cycle imem_ready or dmem_ready is low adds one cycle.
REQ-024 Arithmetic is modulo 2^DATA_WIDTH (ADD/SUB wrap, no flags exported). pc+1 wraps from 2^ADDR_WIDTH-1 to 0.
REQ-025 retired increments by 1 on the cycle an instruction leaves its last state (FETCH entry or HALT entry), and wraps at 16 bits. HALT counts as retired.
REQ-026 Undefined opcode: executes as NOP, sets illegal=1 (sticky until clear), and is counted as retired.
REQ-027 HALT state: halted=1, imem_req=dmem_req=0, no state changes until clear.
REQ-028 imem_req and dmem_req are never high in the same cycle. dmem_we=0 whenever dmem_req=0.
REQ-029 An imem_ready or dmem_ready seen outside the matching request state is ignored.

Reset
REQ-030 When clear=1 at a clk edge: state<=FETCH, pc<=0, IR<=0, all registers<=0, retired<=0, halted<=0, illegal<=0. Outputs take these values from the following cycle.
REQ-031 clear overrides everything, including a pending wait in FETCH/MEM; the abandoned access is dropped and req is low the cycle after clear asserts if clear is still high.
REQ-032 While clear=1, imem_req=dmem_req=0. Fetch from address 0 starts the first cycle after clear deasserts.

Verification
REQ-033 Program LDI r1,5; LDI r2,3; ADD r1,r2; ST r1,@0x10; HALT with zero-wait memories -> mem[0x10]=8, halted=1, retired=5, total cycles 4+4+4+4+3=19 after clear.
REQ-034 LDI r0,0xFF; LDI r1,1; ADD r0,r1 (DATA_WIDTH=8) -> r0=0x00. Follow with JZ r0,0x20 -> pc=0x20 and the next imem_addr=0x20.
REQ-035 Hold imem_ready low for 3 cycles during a fetch, and dmem_ready low for 2 cycles during an LD -> IR/pc stable, req held throughout, and the LD takes exactly 5+3+2 cycles.
REQ-036 Opcode 12 fetched -> illegal=1, no register/memory change, retired increments, next fetch at pc+1.
REQ-037 Assert clear for 1 cycle while in MEM waiting (dmem_ready=0) -> dmem_req=0 the next cycle, pc=0, registers=0, and execution restarts from address 0.
REQ-038 JMP 0xFF then NOP at 0xFF -> the next fetch address wraps to 0x00. Repeat with NUM_REGS=8, DATA_WIDTH=16 to confirm parametrisation.
